// File: rtl/estacionamiento_pkg.sv
// Shared types and defaults for the parking-lot blocks (gate controller, occupancy counter).
package estacionamiento_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ENT_ABIERTA = 2'd1,
    SAL_ABIERTA = 2'd2,
    CIERRE      = 2'd3
  } estado_t;

  typedef enum logic {
    LADO_ENT = 1'b0,
    LADO_SAL = 1'b1
  } lado_t;

  localparam int unsigned CAPACIDAD_DEF = 7;
  localparam int unsigned ANCHO_DEF     = 7;

  function automatic int unsigned ancho_timer(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/control_barreras_temporizador.sv
// Clearable saturating up-counter; fin flags when the count equals the selected limit.
module temporizador #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] limite,
  output logic         fin
);

  logic [W-1:0] cuenta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cuenta <= '0;
    end else if (clr) begin
      cuenta <= '0;
    end else if (cuenta != '1) begin
      cuenta <= cuenta + 1'b1;
    end
  end

  assign fin = (cuenta == limite);

endmodule

// File: rtl/control_barreras.sv
// Single-lane gate controller: arbitrates entry/exit, opens one barrier at a time,
// and pulses the occupancy counter once per completed passage.
module control_barreras
  import estacionamiento_pkg::*;
#(
  parameter int unsigned CAPACIDAD = CAPACIDAD_DEF,
  parameter int unsigned ANCHO     = ANCHO_DEF,
  parameter int unsigned T_ESPERA  = 16,
  parameter int unsigned T_CIERRE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sol_entrada,
  input  logic             sol_salida,
  input  logic             paso,
  input  logic [ANCHO-1:0] espacio,
  output logic             barrera_entrada,
  output logic             barrera_salida,
  output logic             entrada,
  output logic             salida,
  output logic             lleno,
  output logic [1:0]       estado
);

  localparam int unsigned      TW         = ancho_timer(T_ESPERA, T_CIERRE);
  localparam logic [ANCHO-1:0] CAP        = ANCHO'(CAPACIDAD);
  localparam logic [TW-1:0]    LIM_ESPERA = TW'(T_ESPERA - 1);
  localparam logic [TW-1:0]    LIM_CIERRE = TW'(T_CIERRE - 1);

  estado_t       est, est_d;
  lado_t         ultimo, ultimo_d;
  logic          paso_q, flanco;
  logic          elig_ent, elig_sal;
  logic          ent_d, sal_d;
  logic          clr, fin;
  logic [TW-1:0] limite;

  assign flanco   = paso & ~paso_q;
  assign elig_ent = sol_entrada && (espacio < CAP);
  assign elig_sal = sol_salida && (espacio != '0);

  // Timer restarts on every state change; count k is the (k+1)-th cycle in the state.
  assign clr    = (est_d != est);
  assign limite = (est == CIERRE) ? LIM_CIERRE : LIM_ESPERA;

  temporizador #(.W(TW)) u_temporizador (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .limite (limite),
    .fin    (fin)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      est     <= IDLE;
      ultimo  <= LADO_SAL;
      paso_q  <= 1'b0;
      entrada <= 1'b0;
      salida  <= 1'b0;
      lleno   <= 1'b0;
    end else begin
      est     <= est_d;
      ultimo  <= ultimo_d;
      paso_q  <= paso;
      entrada <= ent_d;
      salida  <= sal_d;
      lleno   <= (espacio >= CAP);
    end
  end

  always_comb begin
    est_d    = est;
    ultimo_d = ultimo;
    ent_d    = 1'b0;
    sal_d    = 1'b0;
    unique case (est)
      IDLE: begin
        if (elig_ent && (!elig_sal || ultimo == LADO_SAL)) begin
          est_d    = ENT_ABIERTA;
          ultimo_d = LADO_ENT;
        end else if (elig_sal) begin
          est_d    = SAL_ABIERTA;
          ultimo_d = LADO_SAL;
        end
      end
      ENT_ABIERTA: begin
        if (flanco) begin
          est_d = CIERRE;
          ent_d = 1'b1;
        end else if (fin) begin
          est_d = CIERRE;
        end
      end
      SAL_ABIERTA: begin
        if (flanco) begin
          est_d = CIERRE;
          sal_d = 1'b1;
        end else if (fin) begin
          est_d = CIERRE;
        end
      end
      CIERRE: begin
        if (fin) est_d = IDLE;
      end
      default: est_d = IDLE;
    endcase
  end

  // Barriers decode the state so an asynchronous reset drops them at once.
  assign barrera_entrada = (est == ENT_ABIERTA);
  assign barrera_salida  = (est == SAL_ABIERTA);
  assign estado          = est;

endmodule

// File: tb/tb_control_barreras.sv
// Self-checking bench for control_barreras with a transaction-level reference model.
module tb_control_barreras;

  logic       clk = 1'b0;
  logic       reset;
  logic       sol_entrada, sol_salida, paso;
  logic [6:0] espacio;
  logic       barrera_entrada, barrera_salida, entrada, salida, lleno;
  logic [1:0] estado;

  int tests_run    = 0;
  int tests_failed = 0;
  int viol, n_ent, n_sal;
  int ultimo_m;
  bit cnt_en;
  logic ent_prev, sal_prev;

  control_barreras #(
    .CAPACIDAD (7),
    .ANCHO     (7),
    .T_ESPERA  (16),
    .T_CIERRE  (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sol_entrada     (sol_entrada),
    .sol_salida      (sol_salida),
    .paso            (paso),
    .espacio         (espacio),
    .barrera_entrada (barrera_entrada),
    .barrera_salida  (barrera_salida),
    .entrada         (entrada),
    .salida          (salida),
    .lleno           (lleno),
    .estado          (estado)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Granted side from the eligibility and fairness rules: 0 none, 1 entry, 2 exit.
  function automatic int predecir(bit se, bit ss, int esp, int ult);
    bit e = se && (esp < 7);
    bit s = ss && (esp > 0);
    if (e && s) return (ult == 1) ? 1 : 2;
    if (e) return 1;
    if (s) return 2;
    return 0;
  endfunction

  // One clock; mimics the occupancy counter (espacio moves the cycle after a pulse).
  task automatic step();
    @(posedge clk);
    #1;
    if (cnt_en) begin
      if (ent_prev === 1'b1) espacio = espacio + 7'd1;
      if (sal_prev === 1'b1) espacio = espacio - 7'd1;
    end
    ent_prev = entrada;
    sal_prev = salida;
    if (barrera_entrada && barrera_salida) viol++;
    if (entrada && salida) viol++;
    n_ent += int'(entrada);
    n_sal += int'(salida);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    sol_entrada = 1'b0;
    sol_salida  = 1'b0;
    paso        = 1'b0;
    cnt_en      = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    ent_prev = 1'b0;
    sal_prev = 1'b0;
    ultimo_m = 1;
    viol     = 0;
    n_ent    = 0;
    n_sal    = 0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    sol_entrada = 1'b1;
    sol_salida  = 1'b0;
    paso        = 1'b0;
    espacio     = 7'd0;
    cnt_en      = 1'b0;
    ent_prev    = 1'b0;
    sal_prev    = 1'b0;
    viol = 0; n_ent = 0; n_sal = 0;
    step();
    step();
    tests_run++;
    if ({barrera_entrada, barrera_salida, entrada, salida, lleno} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {barrera_entrada, barrera_salida, entrada, salida, lleno});
    end
    tests_run++;
    if (estado !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_estado: got %0d expected 0", estado);
    end
    reset = 1'b0;
    step();
    tests_run++;
    if (barrera_entrada !== 1'b1 || estado !== 2'd1) begin
      tests_failed++;
      $display("FAIL reset_first_grant: barrera_entrada=%b estado=%0d expected 1/1",
               barrera_entrada, estado);
    end
  endtask

  task automatic test_basico();
    int nb, nc;
    do_reset();
    cnt_en      = 1'b1;
    espacio     = 7'd0;
    sol_entrada = 1'b1;
    step();
    tests_run++;
    if (barrera_entrada !== 1'b1 || estado !== 2'd1) begin
      tests_failed++;
      $display("FAIL basic_grant: barrera_entrada=%b estado=%0d expected 1/1",
               barrera_entrada, estado);
    end
    nb = 1;
    step(); nb += int'(barrera_entrada);
    step(); nb += int'(barrera_entrada);
    paso = 1'b1;
    step();
    tests_run++;
    if (nb !== 3) begin
      tests_failed++;
      $display("FAIL basic_barrier_cycles: got %0d expected 3", nb);
    end
    tests_run++;
    if ({barrera_entrada, entrada, estado} !== 4'b0111) begin
      tests_failed++;
      $display("FAIL basic_pulse: got %b expected 0111", {barrera_entrada, entrada, estado});
    end
    paso        = 1'b0;
    sol_entrada = 1'b0;
    nc = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (estado == 2'd3) nc++;
      else break;
    end
    tests_run++;
    if (nc !== 4 || estado !== 2'd0) begin
      tests_failed++;
      $display("FAIL basic_cierre: cycles=%0d estado=%0d expected 4/0", nc, estado);
    end
    step();
    tests_run++;
    if (n_ent !== 1 || n_sal !== 0) begin
      tests_failed++;
      $display("FAIL basic_pulse_count: ent=%0d sal=%0d expected 1/0", n_ent, n_sal);
    end
  endtask

  task automatic test_lleno();
    int nb;
    do_reset();
    cnt_en      = 1'b1;
    espacio     = 7'd7;
    sol_entrada = 1'b1;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      nb += int'(barrera_entrada | barrera_salida);
    end
    tests_run++;
    if (nb !== 0) begin
      tests_failed++;
      $display("FAIL full_no_grant: barrier cycles %0d expected 0", nb);
    end
    tests_run++;
    if (lleno !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_lleno: got %b expected 1", lleno);
    end
    sol_salida = 1'b1;
    step();
    tests_run++;
    if (barrera_salida !== 1'b1 || estado !== 2'd2) begin
      tests_failed++;
      $display("FAIL full_exit_grant: barrera_salida=%b estado=%0d expected 1/2",
               barrera_salida, estado);
    end
    step();
    paso = 1'b1;
    step();
    tests_run++;
    if (salida !== 1'b1 || barrera_salida !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_exit_pulse: salida=%b barrera_salida=%b expected 1/0",
               salida, barrera_salida);
    end
    paso = 1'b0; sol_entrada = 1'b0; sol_salida = 1'b0;
    for (int i = 0; i < 10 && estado != 2'd0; i++) step();
    tests_run++;
    if (n_sal !== 1 || n_ent !== 0) begin
      tests_failed++;
      $display("FAIL full_pulse_count: ent=%0d sal=%0d expected 0/1", n_ent, n_sal);
    end
  endtask

  task automatic test_alternancia();
    int side, exp_side;
    do_reset();
    cnt_en      = 1'b1;
    espacio     = 7'd3;
    sol_entrada = 1'b1;
    sol_salida  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 20 && !(barrera_entrada || barrera_salida); i++) step();
      side     = barrera_entrada ? 1 : (barrera_salida ? 2 : 0);
      exp_side = predecir(1'b1, 1'b1, int'(espacio), ultimo_m);
      ultimo_m = (exp_side == 1) ? 0 : 1;
      tests_run++;
      if (side !== exp_side) begin
        tests_failed++;
        $display("FAIL alternate_grant_%0d: side %0d expected %0d", k, side, exp_side);
      end
      step();
      paso = 1'b1;
      step();
      paso = 1'b0;
    end
    sol_entrada = 1'b0;
    sol_salida  = 1'b0;
    for (int i = 0; i < 10 && estado != 2'd0; i++) step();
    tests_run++;
    if (viol !== 0 || n_ent !== 2 || n_sal !== 2) begin
      tests_failed++;
      $display("FAIL alternate_totals: viol=%0d ent=%0d sal=%0d expected 0/2/2",
               viol, n_ent, n_sal);
    end
  endtask

  task automatic test_timeout();
    int nb, nlow;
    do_reset();
    cnt_en      = 1'b1;
    espacio     = 7'd2;
    sol_entrada = 1'b1;
    step();
    nb = 0;
    for (int i = 0; i < 40 && barrera_entrada; i++) begin
      nb++;
      step();
    end
    tests_run++;
    if (nb !== 16) begin
      tests_failed++;
      $display("FAIL timeout_open_cycles: got %0d expected 16", nb);
    end
    nlow = 0;
    for (int i = 0; i < 40 && !barrera_entrada; i++) begin
      nlow++;
      step();
    end
    tests_run++;
    if (nlow !== 5) begin
      tests_failed++;
      $display("FAIL timeout_regrant_gap: got %0d expected 5", nlow);
    end
    tests_run++;
    if (n_ent !== 0) begin
      tests_failed++;
      $display("FAIL timeout_no_pulse: got %0d expected 0", n_ent);
    end
  endtask

  task automatic test_paso_alto();
    int nb;
    do_reset();
    cnt_en  = 1'b1;
    espacio = 7'd1;
    paso    = 1'b1;
    step();
    step();
    sol_entrada = 1'b1;
    step();
    sol_entrada = 1'b0;
    nb = 0;
    for (int i = 0; i < 5; i++) begin
      nb += int'(barrera_entrada);
      step();
    end
    tests_run++;
    if (nb !== 5 || barrera_entrada !== 1'b1 || n_ent !== 0) begin
      tests_failed++;
      $display("FAIL held_paso_no_pulse: open=%0d barrier=%b pulses=%0d expected 5/1/0",
               nb, barrera_entrada, n_ent);
    end
    paso = 1'b0;
    step();
    paso = 1'b1;
    step();
    tests_run++;
    if (entrada !== 1'b1 || barrera_entrada !== 1'b0) begin
      tests_failed++;
      $display("FAIL held_paso_new_edge: entrada=%b barrier=%b expected 1/0",
               entrada, barrera_entrada);
    end
    paso = 1'b0;
  endtask

  task automatic test_reset_sal();
    do_reset();
    cnt_en     = 1'b1;
    espacio    = 7'd4;
    sol_salida = 1'b1;
    step();
    tests_run++;
    if (estado !== 2'd2) begin
      tests_failed++;
      $display("FAIL midreset_setup: estado %0d expected 2", estado);
    end
    step();
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({barrera_entrada, barrera_salida, entrada, salida, estado} !== 6'b0) begin
      tests_failed++;
      $display("FAIL midreset_async: got %b expected 000000",
               {barrera_entrada, barrera_salida, entrada, salida, estado});
    end
    espacio     = 7'd3;
    sol_entrada = 1'b1;
    #1;
    reset    = 1'b0;
    ent_prev = 1'b0;
    sal_prev = 1'b0;
    step();
    tests_run++;
    if (barrera_entrada !== 1'b1 || barrera_salida !== 1'b0 || n_sal !== 0) begin
      tests_failed++;
      $display("FAIL midreset_tie: ent=%b sal=%b pulses=%0d expected 1/0/0",
               barrera_entrada, barrera_salida, n_sal);
    end
  endtask

  task automatic test_aleatorio();
    int esp, pred, side, d, nb, exp_nb;
    bit se, ss;
    logic [1:0] exp_p;
    do_reset();
    cnt_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      esp  = int'($urandom_range(0, 7));
      se   = 1'($urandom % 2);
      ss   = 1'($urandom % 2);
      pred = predecir(se, ss, esp, ultimo_m);
      espacio     = 7'(esp);
      sol_entrada = se;
      sol_salida  = ss;
      step();
      side = barrera_entrada ? 1 : (barrera_salida ? 2 : 0);
      tests_run++;
      if (side !== pred) begin
        tests_failed++;
        $display("FAIL rand_grant_%0d: side %0d expected %0d (esp=%0d se=%0b ss=%0b)",
                 t, side, pred, esp, se, ss);
      end
      tests_run++;
      if (lleno !== (esp >= 7)) begin
        tests_failed++;
        $display("FAIL rand_lleno_%0d: got %b expected %0b", t, lleno, esp >= 7);
      end
      if (pred != 0) ultimo_m = (pred == 1) ? 0 : 1;
      if ($urandom % 2 == 0) begin
        sol_entrada = 1'b0;
        sol_salida  = 1'b0;
      end
      d = ($urandom % 3 == 0) ? int'($urandom_range(17, 22)) : int'($urandom_range(1, 15));
      nb = 0;
      for (int i = 1; i <= 30; i++) begin
        if (!(barrera_entrada || barrera_salida)) break;
        nb++;
        if (i == d) paso = 1'b1;
        step();
      end
      exp_nb = (pred == 0) ? 0 : ((d < 16) ? d : 16);
      exp_p  = (pred != 0 && d < 16) ? ((pred == 1) ? 2'b10 : 2'b01) : 2'b00;
      tests_run++;
      if (nb !== exp_nb) begin
        tests_failed++;
        $display("FAIL rand_open_%0d: got %0d expected %0d", t, nb, exp_nb);
      end
      tests_run++;
      if ({entrada, salida} !== exp_p) begin
        tests_failed++;
        $display("FAIL rand_pulse_%0d: got %b expected %b", t, {entrada, salida}, exp_p);
      end
      paso        = 1'b0;
      sol_entrada = 1'b0;
      sol_salida  = 1'b0;
      for (int i = 0; i < 20 && estado != 2'd0; i++) step();
    end
    tests_run++;
    if (viol !== 0 || estado !== 2'd0) begin
      tests_failed++;
      $display("FAIL rand_invariants: viol=%0d estado=%0d expected 0/0", viol, estado);
    end
  endtask

  initial begin
    test_reset();
    test_basico();
    test_lleno();
    test_alternancia();
    test_timeout();
    test_paso_alto();
    test_reset_sal();
    test_aleatorio();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
